// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: on a miss, fetches a whole cache block as sequential word reads,
// streams the returned words into the data array, then writes the tag.
module cache_fill_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       miss,
    input  logic [ADDR_W-1:0]          miss_addr,
    input  logic                       grant,
    input  logic                       mem_data_valid,
    input  logic [DATA_W-1:0]          mem_data_in,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_rd_en,
    output logic                       busy,
    output logic                       wr_word_en,
    output logic [$clog2(WORDS)-1:0]   wr_word_idx,
    output logic [DATA_W-1:0]          wr_word_data,
    output logic                       tag_wr_en,
    output logic                       fill_done
);
    localparam int IW  = $clog2(WORDS);
    localparam int OFF = IW + 1;
    typedef enum logic [1:0] {IDLE, FILL, WAIT, DONE} state_t;
    state_t                state_q;
    logic [ADDR_W-1:OFF]   blk_addr_q;
    logic [IW:0]           iss_cnt_q;
    logic [IW-1:0]         rcv_cnt_q;
    logic                  fill, rx;
    logic                  unused_ok;
    assign unused_ok = ^miss_addr[OFF-1:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            blk_addr_q <= '0;
            iss_cnt_q  <= '0;
            rcv_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (miss) begin
                    blk_addr_q <= miss_addr[ADDR_W-1:OFF];
                    iss_cnt_q  <= '0;
                    rcv_cnt_q  <= '0;
                    state_q    <= FILL;
                end
                FILL, WAIT: begin
                    if (state_q == FILL && grant) begin
                        iss_cnt_q <= iss_cnt_q + 1'b1;
                        if (iss_cnt_q == (IW+1)'(WORDS-1)) state_q <= WAIT;
                    end
                    // the final word wins over the issue-complete transition
                    if (mem_data_valid) begin
                        rcv_cnt_q <= rcv_cnt_q + 1'b1;
                        if (rcv_cnt_q == IW'(WORDS-1)) state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign fill         = state_q == FILL;
    assign rx           = fill || state_q == WAIT;
    assign mem_rd_en    = fill && grant;
    assign mem_addr     = fill ? {blk_addr_q, iss_cnt_q[IW-1:0], 1'b0} : '0;
    assign wr_word_en   = rx && mem_data_valid;
    assign wr_word_idx  = wr_word_en ? rcv_cnt_q : '0;
    assign wr_word_data = wr_word_en ? mem_data_in : '0;
    assign tag_wr_en    = state_q == DONE;
    assign fill_done    = state_q == DONE;
    assign busy         = state_q != IDLE;
endmodule
